issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  Instruction queue and issue controller between the fetcher and the decoder.
//  - Buffers fetched {instr, pc} pairs.
//  - Releases one instruction per cycle to the decoder, and only when the ROB and the target unit can accept it.
//  - Target unit is RS or LSB, classified by opcode.
//  - Clears all in-flight queue state on a misprediction flush.
// PARAMETERS
//  DEPTH_LOG  4  log2 of queue depth (DEPTH = 16 entries)
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous, active-low reset
//  rdy             in   1   global ready; low freezes the block
//  in_fetch_valid  in   1   fetcher presents an instruction this cycle
//  in_fetch_instr  in   32  instruction word
//  in_fetch_pc     in   32  instruction pc
//  out_fetch_ready out  1   queue can accept (count < DEPTH and state RUN)
//  in_rob_full     in   1   ROB has <=1 free entry
//  in_rs_full      in   1   RS has <=1 free entry
//  in_lsb_full     in   1   LSB has <=1 free entry
//  in_flush        in   1   misprediction flush, from the ROB
//  out_dec_valid   out  1   out_dec_* hold an instruction to decode this cycle
//  out_dec_instr   out  32  instruction to decoder; 32'h0 when not valid
//  out_dec_pc      out  32  pc to decoder; 32'h0 when not valid
//  out_count       out  DEPTH_LOG+1  current queue occupancy
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - head = tail = count = 0; state = RUN.
//   - out_dec_valid = 0; out_dec_instr = out_dec_pc = 0.
//  Queue:
//   - Circular buffer; head/tail are DEPTH_LOG bits and wrap modulo DEPTH.
//   - Push when in_fetch_valid && out_fetch_ready && rdy.
//   - Push and pop in the same cycle both take effect; count is unchanged.
//   - A push while full is refused (out_fetch_ready=0), even if a pop occurs that cycle.
//  Classification of the head opcode instr[6:0]:
//   - LSB: 0000011 (load), 0100011 (store).
//   - RS: 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011.
//   - Anything else is illegal.
//  Issue condition (evaluated in state RUN, rdy=1, count>0):
//   - LSB class: !in_rob_full && !in_lsb_full.
//   - RS class: !in_rob_full && !in_rs_full.
//   - Illegal class: popped silently, never issued.
//  Issue timing:
//   - On issue: pop head; next cycle out_dec_valid=1 with that instr/pc (registered).
//   - Otherwise out_dec_valid=0 and instr/pc are 0 (decoder treats opcode 0 as no-op).
//   - Latency: an instruction pushed at edge E appears on out_dec_* no earlier than the cycle after edge E+1.
//   - Program order is preserved; at most 1 issue per cycle.
//   - out_dec_valid is never high for 2 cycles with the same queue entry.
//  Full thresholds: the "<=1 free" full definition covers the one registered instruction in flight.
//  State machine:
//   - RUN -> FLUSH when in_flush=1: at that edge the queue empties (count=0, head=tail), out_dec_valid=0, and the push that cycle is discarded.
//   - FLUSH -> RUN unconditionally after 1 cycle; out_fetch_ready=0 in FLUSH.
//   - in_flush in FLUSH keeps state FLUSH for one more cycle.
//  rdy=0:
//   - No push/pop; head/tail/count/state held.
//   - out_dec_valid/instr/pc are cleared at the edge, so no double dispatch.
//  Priority: reset > flush > rdy > push/pop.
// TESTING
//  1. Reset then push addi (32'h00100093, pc 0) with all full=0 -> out_dec_valid=1, instr 32'h00100093, pc 0, two cycles after the push edge; out_count back to 0.
//  2. Push 16 instructions with in_rob_full=1 -> out_count=16, out_fetch_ready=0, 17th refused; drop full -> 16 issues in order on consecutive cycles.
//  3. Head lw (32'h0000a083), in_lsb_full=1, in_rs_full=0 -> no issue; add after it is also held (in-order); release lsb_full -> lw then add.
//  4. Queue holds 5 entries, in_flush=1 together with in_fetch_valid -> next cycle count=0, out_fetch_ready=0, out_dec_valid=0; following cycle RUN, ready=1.
//  5. Head 32'hFFFFFFFF (illegal) then addi -> illegal popped with out_dec_valid=0; addi issued the next cycle.
//  6. Wrap: 20 push/pop pairs at steady state with count=3 -> order preserved across pointer wrap; rdy low 3 cycles mid-stream -> no pops, no valid, resumes with the same head.

Source files
------------

// File: rtl/issue_scheduler.sv
// Instruction queue between fetcher and decoder: buffers {instr, pc} pairs and issues one per
// cycle, in order, when the ROB and the target unit (RS or LSB) can accept it.
module issue_scheduler #(
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_fetch_valid,
    input  logic [31:0]          in_fetch_instr,
    input  logic [31:0]          in_fetch_pc,
    output logic                 out_fetch_ready,
    input  logic                 in_rob_full,
    input  logic                 in_rs_full,
    input  logic                 in_lsb_full,
    input  logic                 in_flush,
    output logic                 out_dec_valid,
    output logic [31:0]          out_dec_instr,
    output logic [31:0]          out_dec_pc,
    output logic [DEPTH_LOG:0]   out_count
);

    localparam int unsigned Depth = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DepthCnt = {1'b1, {DEPTH_LOG{1'b0}}};

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG-1:0]   head_q, head_d;
    logic [DEPTH_LOG-1:0]   tail_q, tail_d;
    logic [DEPTH_LOG:0]     count_q, count_d;
    logic                   dec_valid_q, dec_valid_d;
    logic [31:0]            dec_instr_q, dec_instr_d;
    logic [31:0]            dec_pc_q, dec_pc_d;

    logic [63:0]            mem_q [Depth];
    logic [63:0]            head_entry;
    logic [6:0]             head_op;
    logic                   is_lsb, is_rs;
    logic                   push, pop, issue_ok;

    assign head_entry      = mem_q[head_q];
    assign head_op         = head_entry[6:0];
    assign out_fetch_ready = (state_q == StRun) && (count_q != DepthCnt);

    always_comb begin
        is_lsb = 1'b0;
        is_rs  = 1'b0;
        unique case (head_op)
            7'b0000011, 7'b0100011: is_lsb = 1'b1;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0010011, 7'b0110011: is_rs = 1'b1;
            default: ;
        endcase
    end

    // Illegal opcodes are popped without issuing, so they never block the queue.
    assign issue_ok = (state_q == StRun) && (count_q != '0) &&
                      ((!is_lsb && !is_rs) ||
                       (is_lsb && !in_rob_full && !in_lsb_full) ||
                       (is_rs && !in_rob_full && !in_rs_full));

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        dec_valid_d = 1'b0;
        dec_instr_d = '0;
        dec_pc_d    = '0;
        push        = 1'b0;
        pop         = 1'b0;
        if (in_flush) begin
            state_d = StFlush;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            if (state_q == StFlush) begin
                state_d = StRun;
            end
            push = in_fetch_valid && out_fetch_ready;
            pop  = issue_ok;
            if (pop) begin
                head_d = head_q + 1'b1;
                if (is_lsb || is_rs) begin
                    dec_valid_d = 1'b1;
                    dec_instr_d = head_entry[31:0];
                    dec_pc_d    = head_entry[63:32];
                end
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    // Storage needs no reset; only entries between head and tail are ever read out.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[tail_q] <= {in_fetch_pc, in_fetch_instr};
        end
    end

    assign out_dec_valid = dec_valid_q;
    assign out_dec_instr = dec_instr_q;
    assign out_dec_pc    = dec_pc_q;
    assign out_count     = count_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Randomised and directed bench for issue_scheduler, checked against a queue-based reference
// model of the fetch/issue rules.
module tb_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst, rdy, fv, rob_full, rs_full, lsb_full, flush;
    logic [31:0] f_instr, f_pc;
    logic        fetch_ready, dec_valid;
    logic [31:0] dec_instr, dec_pc;
    logic [4:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_run;
    bit          m_valid;
    logic [31:0] m_instr, m_pc;
    logic [31:0] next_pc;

    always #5 clk = ~clk;

    issue_scheduler #(.DEPTH_LOG(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_fetch_valid (fv),
        .in_fetch_instr (f_instr),
        .in_fetch_pc    (f_pc),
        .out_fetch_ready(fetch_ready),
        .in_rob_full    (rob_full),
        .in_rs_full     (rs_full),
        .in_lsb_full    (lsb_full),
        .in_flush       (flush),
        .out_dec_valid  (dec_valid),
        .out_dec_instr  (dec_instr),
        .out_dec_pc     (dec_pc),
        .out_count      (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 = RS, 1 = LSB, 2 = illegal
    function automatic int op_class(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        if (op == 7'h03 || op == 7'h23) return 1;
        if (op == 7'h37 || op == 7'h17 || op == 7'h6f || op == 7'h67 ||
            op == 7'h63 || op == 7'h13 || op == 7'h33) return 0;
        return 2;
    endfunction

    // Apply the current inputs to the model, clock once, then compare all outputs.
    task automatic cycle();
        bit   can_push;
        int   cls;
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_run = 1'b1;
            m_valid = 1'b0; m_instr = '0; m_pc = '0;
        end else if (flush) begin
            mq.delete();
            m_run = 1'b0;
            m_valid = 1'b0; m_instr = '0; m_pc = '0;
        end else if (!rdy) begin
            m_valid = 1'b0; m_instr = '0; m_pc = '0;
        end else begin
            can_push = m_run && (mq.size() < 16);
            m_valid = 1'b0; m_instr = '0; m_pc = '0;
            if (m_run && mq.size() > 0) begin
                cls = op_class(mq[0].instr);
                if (cls == 2) begin
                    void'(mq.pop_front());
                end else if (!rob_full && ((cls == 0 && !rs_full) || (cls == 1 && !lsb_full)))
                begin
                    e = mq.pop_front();
                    m_valid = 1'b1; m_instr = e.instr; m_pc = e.pc;
                end
            end
            if (fv && can_push) begin
                e.instr = f_instr;
                e.pc = f_pc;
                mq.push_back(e);
            end
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("dec_valid", {31'b0, dec_valid}, {31'b0, m_valid});
        check_eq("dec_instr", dec_instr, m_instr);
        check_eq("dec_pc", dec_pc, m_pc);
        check_eq("count", {27'b0, count}, mq.size());
        check_eq("fetch_ready", {31'b0, fetch_ready}, {31'b0, (m_run && mq.size() < 16)});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        fv = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input logic [31:0] instr);
        fv = 1'b1;
        f_instr = instr;
        f_pc = next_pc;
        next_pc += 4;
        cycle();
        fv = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9] = '{7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33};
        logic [31:0] r;
        int          idx;
        r = $urandom;
        idx = $urandom_range(0, 10);
        if (idx < 9) r[6:0] = ops[idx];
        return r;
    endfunction

    initial begin
        rst = 1'b0; rdy = 1'b1; fv = 1'b0; f_instr = '0; f_pc = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; flush = 1'b0;
        next_pc = '0;
        m_run = 1'b1; m_valid = 1'b0; m_instr = '0; m_pc = '0;
        @(negedge clk);
        idle(2);
        rst = 1'b1;

        // Single addi: issued two cycles after the push edge.
        push(32'h00100093);
        cycle();
        check_eq("addi_instr", dec_instr, 32'h00100093);
        idle(2);

        // Fill to 16 behind a full ROB; 17th refused; then drain in order.
        rob_full = 1'b1;
        for (int i = 0; i < 17; i++) push(32'h00000013 | (i << 20));
        check_eq("full_count", {27'b0, count}, 32'd16);
        rob_full = 1'b0;
        idle(18);

        // Load held by full LSB blocks the add behind it.
        lsb_full = 1'b1;
        push(32'h0000a083);
        push(32'h002081b3);
        idle(3);
        lsb_full = 1'b0;
        idle(4);

        // Flush with a concurrent push.
        rob_full = 1'b1;
        for (int i = 0; i < 5; i++) push(rand_instr());
        flush = 1'b1;
        push(32'h00100093);
        check_eq("flush_ready", {31'b0, fetch_ready}, 32'd0);
        flush = 1'b0;
        idle(2);
        rob_full = 1'b0;

        // Illegal head popped silently.
        push(32'hFFFFFFFF);
        push(32'h00100093);
        idle(4);

        // Steady state at count 3 across pointer wrap, with a rdy gap.
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h00000013 | (i << 20));
        rob_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = !(i >= 8 && i < 11);
            push(32'h00000033 | (i << 15));
        end
        rdy = 1'b1;
        idle(6);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            rob_full = ($urandom_range(0, 3) == 0);
            rs_full = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            fv = ($urandom_range(0, 9) < 7);
            f_instr = rand_instr();
            f_pc = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
